// File: rtl/vga_timing_fetch_if.sv
// vga_timing_fetch_if: pixel FIFO read side and video output bundle for vga_timing_fetch.
//   pix_data     FIFO head pixel {R,G,B}, valid when pix_empty=0
//   pix_empty    FIFO empty
//   pix_rd       FIFO pop (combinational in the timing block)
//   video_hs/vs  active-low syncs, registered
//   video_blank  1 = active display pixel, registered
//   video_rgb    pixel colour, registered
//   frame_start  pulse at the first pixel of a frame
//   line_start   pulse at the first pixel of every active line
//   underflow    sticky FIFO underflow flag
// master: the timing/fetch block. slave: FIFO + display side.
interface vga_timing_fetch_if;
    logic [23:0] pix_data;
    logic        pix_empty;
    logic        pix_rd;
    logic        video_hs;
    logic        video_vs;
    logic        video_blank;
    logic [23:0] video_rgb;
    logic        frame_start;
    logic        line_start;
    logic        underflow;

    modport master (
        input  pix_data,
        input  pix_empty,
        output pix_rd,
        output video_hs,
        output video_vs,
        output video_blank,
        output video_rgb,
        output frame_start,
        output line_start,
        output underflow
    );

    modport slave (
        output pix_data,
        output pix_empty,
        input  pix_rd,
        input  video_hs,
        input  video_vs,
        input  video_blank,
        input  video_rgb,
        input  frame_start,
        input  line_start,
        input  underflow
    );
endinterface

// File: rtl/vga_timing_fetch.sv
// vga_timing_fetch: pixel-clock video timing generator that pops one pixel per active pixel
// from a first-word-fall-through FIFO and drives registered HS/VS/BLANK/RGB.
// Ports:
//   i_pixel_clk  pixel clock
//   i_pixel_rst  synchronous active-high reset
//   io_vid       vga_timing_fetch_if.master (FIFO read side, video outputs, markers)
// Line/frame order: active, front porch, sync pulse, back porch.
module vga_timing_fetch #(
    parameter int unsigned HDISP  = 800,
    parameter int unsigned VDISP  = 480,
    parameter int unsigned HFP    = 40,
    parameter int unsigned HPULSE = 48,
    parameter int unsigned HBP    = 40,
    parameter int unsigned VFP    = 13,
    parameter int unsigned VPULSE = 3,
    parameter int unsigned VBP    = 29
) (
    input  logic               i_pixel_clk,
    input  logic               i_pixel_rst,
    vga_timing_fetch_if.master io_vid
);

    localparam int unsigned HTOTAL = HDISP + HFP + HPULSE + HBP;
    localparam int unsigned VTOTAL = VDISP + VFP + VPULSE + VBP;
    localparam int unsigned HW     = $clog2(HTOTAL);
    localparam int unsigned VW     = $clog2(VTOTAL);

    localparam logic [HW-1:0] H_DISP_END = HW'(HDISP);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(HDISP + HFP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(HDISP + HFP + HPULSE);
    localparam logic [HW-1:0] H_LAST     = HW'(HTOTAL - 1);
    localparam logic [VW-1:0] V_DISP_END = VW'(VDISP);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(VDISP + VFP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(VDISP + VFP + VPULSE);
    localparam logic [VW-1:0] V_LAST     = VW'(VTOTAL - 1);

    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic          r_hs;
    logic          r_vs;
    logic          r_blank;
    logic [23:0]   r_rgb;
    logic          r_underflow;

    logic w_h_wrap;
    logic w_v_active;
    logic w_active;
    logic w_hs_n;
    logic w_vs_n;
    logic w_pix_rd;
    logic w_line_first;

    always_comb begin
        w_h_wrap     = (r_hcnt == H_LAST);
        w_v_active   = (r_vcnt < V_DISP_END);
        w_active     = (r_hcnt < H_DISP_END) && w_v_active;
        w_hs_n       = !((r_hcnt >= H_SYNC_BEG) && (r_hcnt < H_SYNC_END));
        w_vs_n       = !((r_vcnt >= V_SYNC_BEG) && (r_vcnt < V_SYNC_END));
        w_line_first = (r_hcnt == '0) && !i_pixel_rst;
        // Markers and pop are gated during reset so nothing upstream moves while held.
        w_pix_rd     = w_active && !io_vid.pix_empty && !i_pixel_rst;
    end

    always_ff @(posedge i_pixel_clk) begin
        if (i_pixel_rst) begin
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_hs        <= 1'b1;
            r_vs        <= 1'b1;
            r_blank     <= 1'b0;
            r_rgb       <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_hcnt <= w_h_wrap ? '0 : r_hcnt + 1'b1;
            if (w_h_wrap) begin
                r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1;
            end
            r_hs    <= w_hs_n;
            r_vs    <= w_vs_n;
            r_blank <= w_active;
            // A missing pixel is skipped (shown black), never delayed, so timing never stalls.
            r_rgb   <= w_pix_rd ? io_vid.pix_data : '0;
            if (w_active && io_vid.pix_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign io_vid.pix_rd      = w_pix_rd;
    assign io_vid.frame_start = w_line_first && (r_vcnt == '0);
    assign io_vid.line_start  = w_line_first && w_v_active;
    assign io_vid.video_hs    = r_hs;
    assign io_vid.video_vs    = r_vs;
    assign io_vid.video_blank = r_blank;
    assign io_vid.video_rgb   = r_rgb;
    assign io_vid.underflow   = r_underflow;

endmodule

// File: tb/tb_vga_timing_fetch.sv
// Bench for vga_timing_fetch with small timing: 14 pixels per line, 8 lines per frame.
// A reference model predicts each cycle's combinational outputs directly and pushes the
// expected registered outputs into a queue that is popped one cycle later.
module tb_vga_timing_fetch;

    localparam int HDISP  = 8;
    localparam int HFP    = 2;
    localparam int HPULSE = 3;
    localparam int HBP    = 1;
    localparam int VDISP  = 4;
    localparam int VFP    = 1;
    localparam int VPULSE = 2;
    localparam int VBP    = 1;
    localparam int HTOT   = 14;
    localparam int VTOT   = 8;
    localparam int FRAME  = HTOT * VTOT;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        blank;
        logic [23:0] rgb;
        logic        uf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timing_fetch_if vif ();

    vga_timing_fetch #(
        .HDISP  (HDISP),
        .VDISP  (VDISP),
        .HFP    (HFP),
        .HPULSE (HPULSE),
        .HBP    (HBP),
        .VFP    (VFP),
        .VPULSE (VPULSE),
        .VBP    (VBP)
    ) dut (
        .i_pixel_clk (clk),
        .i_pixel_rst (rst),
        .io_vid      (vif)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    int   m_h = 0;
    int   m_v = 0;
    logic m_uf = 1'b0;
    int   fifo_idx = 0;
    int   mode = 0;
    logic pe = 1'b0;
    int   cyc = 0;
    int   last_ls_cyc = -1;
    int   cnt_hs, cnt_vs, cnt_blank, cnt_rd, cnt_fs, cnt_ls;
    logic last_fs, last_blank, last_uf, last_hs, last_vs;
    logic [23:0] last_rgb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // mode 0: FIFO never empty; 1: empty only at 3rd active pixel of line 0;
    // 2: empty everywhere outside the active region.
    task automatic drive_inputs();
        case (mode)
            1:       pe = (m_v == 0) && (m_h == 2);
            2:       pe = !((m_h < HDISP) && (m_v < VDISP));
            default: pe = 1'b0;
        endcase
        vif.pix_empty = pe;
        vif.pix_data  = 24'(fifo_idx);
    endtask

    task automatic set_mode(input int m);
        mode = m;
        drive_inputs();
    endtask

    task automatic clr_counts();
        cnt_hs = 0; cnt_vs = 0; cnt_blank = 0; cnt_rd = 0; cnt_fs = 0; cnt_ls = 0;
    endtask

    task automatic tick();
        exp_t e;
        logic act, erd, efs, els, uf_n;
        @(negedge clk);
        act  = (m_h < HDISP) && (m_v < VDISP);
        erd  = !rst && act && !pe;
        efs  = !rst && (m_h == 0) && (m_v == 0);
        els  = !rst && (m_h == 0) && (m_v < VDISP);
        chk("pix_rd", 32'(vif.pix_rd), 32'(erd));
        chk("frame_start", 32'(vif.frame_start), 32'(efs));
        chk("line_start", 32'(vif.line_start), 32'(els));
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("video_hs", 32'(vif.video_hs), 32'(e.hs));
            chk("video_vs", 32'(vif.video_vs), 32'(e.vs));
            chk("video_blank", 32'(vif.video_blank), 32'(e.blank));
            chk("video_rgb", 32'(vif.video_rgb), 32'(e.rgb));
            chk("underflow", 32'(vif.underflow), 32'(e.uf));
        end
        if (vif.line_start && !vif.frame_start && last_ls_cyc >= 0)
            chk("ls_gap", 32'(cyc - last_ls_cyc), 32'(HTOT));
        if (vif.line_start) last_ls_cyc = cyc;
        cnt_hs    += int'(!vif.video_hs);
        cnt_vs    += int'(!vif.video_vs);
        cnt_blank += int'(vif.video_blank);
        cnt_rd    += int'(vif.pix_rd);
        cnt_fs    += int'(vif.frame_start);
        cnt_ls    += int'(vif.line_start);
        last_fs    = vif.frame_start;
        last_blank = vif.video_blank;
        last_uf    = vif.underflow;
        last_hs    = vif.video_hs;
        last_vs    = vif.video_vs;
        last_rgb   = vif.video_rgb;
        uf_n = rst ? 1'b0 : (m_uf | (act && pe));
        if (rst) begin
            e = '{hs: 1'b1, vs: 1'b1, blank: 1'b0, rgb: 24'h0, uf: 1'b0};
        end else begin
            e.hs    = !((m_h >= HDISP + HFP) && (m_h < HDISP + HFP + HPULSE));
            e.vs    = !((m_v >= VDISP + VFP) && (m_v < VDISP + VFP + VPULSE));
            e.blank = act;
            e.rgb   = erd ? 24'(fifo_idx) : 24'h0;
            e.uf    = uf_n;
        end
        sb_q.push_back(e);
        @(posedge clk);
        cyc++;
        m_uf = uf_n;
        if (erd) fifo_idx++;
        if (rst) begin
            m_h = 0;
            m_v = 0;
        end else if (m_h == HTOT - 1) begin
            m_h = 0;
            m_v = (m_v == VTOT - 1) ? 0 : m_v + 1;
        end else begin
            m_h = m_h + 1;
        end
        #1;
        drive_inputs();
    endtask

    task automatic run_frame();
        clr_counts();
        for (int i = 0; i < FRAME; i++) tick();
    endtask

    initial begin
        bit found;
        clr_counts();
        set_mode(0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("reset_hs", 32'(last_hs), 32'd1);
        chk("reset_vs", 32'(last_vs), 32'd1);
        chk("reset_blank", 32'(last_blank), 32'd0);
        chk("reset_rgb", 32'(last_rgb), 32'd0);
        chk("reset_uf", 32'(last_uf), 32'd0);
        rst = 1'b0;

        // Timing and data path: three full frames, FIFO never empty.
        for (int f = 0; f < 3; f++) begin
            run_frame();
            chk("hs_low_cycles", 32'(cnt_hs), 32'(VTOT * HPULSE));
            chk("vs_low_cycles", 32'(cnt_vs), 32'(VPULSE * HTOT));
            chk("blank_cycles", 32'(cnt_blank), 32'(HDISP * VDISP));
            chk("pops_per_frame", 32'(cnt_rd), 32'(HDISP * VDISP));
            chk("frame_starts", 32'(cnt_fs), 32'd1);
            chk("line_starts", 32'(cnt_ls), 32'(VDISP));
        end
        chk("fifo_words_after_3f", 32'(fifo_idx), 32'(3 * HDISP * VDISP));

        // Underflow at the 3rd pixel of line 0, then sticky across the next frame.
        set_mode(1);
        run_frame();
        chk("uf_pops", 32'(cnt_rd), 32'(HDISP * VDISP - 1));
        chk("uf_set", 32'(last_uf), 32'd1);
        set_mode(0);
        run_frame();
        chk("uf_sticky", 32'(last_uf), 32'd1);
        chk("uf_next_pops", 32'(cnt_rd), 32'(HDISP * VDISP));

        // Mid-frame reset at line 2, pixel 5.
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            if (m_v == 2 && m_h == 5) found = 1'b1;
            else tick();
        end
        chk("midreset_reached", 32'(found), 32'd1);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rel_frame_start", 32'(last_fs), 32'd1);
        chk("rel_hs", 32'(last_hs), 32'd1);
        chk("rel_vs", 32'(last_vs), 32'd1);
        chk("rel_blank", 32'(last_blank), 32'd0);
        chk("rel_rgb", 32'(last_rgb), 32'd0);
        chk("rel_uf", 32'(last_uf), 32'd0);
        tick();
        chk("rel_blank_rise", 32'(last_blank), 32'd1);
        for (int i = 2; i < FRAME; i++) tick();

        // FIFO empty only during blanking: no underflow, full pop count, markers intact.
        set_mode(2);
        for (int f = 0; f < 2; f++) begin
            run_frame();
            chk("blankempty_pops", 32'(cnt_rd), 32'(HDISP * VDISP));
            chk("blankempty_uf", 32'(last_uf), 32'd0);
            chk("blankempty_fs", 32'(cnt_fs), 32'd1);
            chk("blankempty_ls", 32'(cnt_ls), 32'(VDISP));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
